delay_line_param: RTL and testbench

- Parametrised successor to the fixed 5-bit single-stage delay register in the multicycle datapath.
- Provides a DEPTH-stage shift pipeline of WIDTH-bit words, each with a valid tag. Output delay is selectable at runtime through a tap mux.
- Adds stall (enable), flush, asynchronous reset, a selectable capture edge and an occupancy counter.
- Used to carry register-address fields (rd/rt) and similar control words across multicycle states. The default configuration is a drop-in for the 1-cycle negedge 5-bit delay.

---
 rtl/delay_line_param.sv | 87 ++++++++
 tb/tb_delay_line_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/delay_line_param.sv
// Parametrised multi-stage delay line for register-address fields and other control words.
// Each stage carries a valid tag. The output tap can be changed at run time, and the design tracks how many stages hold valid data.
module delay_line_param #(
  parameter int                 WIDTH     = 5,
  parameter int                 DEPTH     = 4,
  parameter bit                 NEG_EDGE  = 1'b1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] a_delayed,
  output logic             a_delayed_valid,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  // flush wins over en; a flush keeps the data words and clears only the valid tags
  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    occ_d = occ_q;
    if (flush) begin
      v_d   = '0;
      occ_d = '0;
    end else if (en) begin
      s_d[0] = a;
      v_d[0] = a_valid;
      for (int i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      occ_d = occ_q + CNT_W'(a_valid) - CNT_W'(v_q[DEPTH-1]);
    end
  end

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) s_q[i] <= RESET_VAL;
        v_q   <= '0;
        occ_q <= '0;
      end else begin
        s_q   <= s_d;
        v_q   <= v_d;
        occ_q <= occ_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) s_q[i] <= RESET_VAL;
        v_q   <= '0;
        occ_q <= '0;
      end else begin
        s_q   <= s_d;
        v_q   <= v_d;
        occ_q <= occ_d;
      end
    end
  end

  // Tap values past the last stage fall through to the default, which is the last stage.
  always_comb begin
    a_delayed       = s_q[DEPTH-1];
    a_delayed_valid = v_q[DEPTH-1];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        a_delayed       = s_q[i];
        a_delayed_valid = v_q[i];
      end
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_delay_line_param.sv
// Directed bench for delay_line_param: a default negedge 5x4 instance and a posedge 32x3 instance.
// Expected values come from constants and from scoreboard queues.
module tb_delay_line_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en, flush, a_valid;
  logic [4:0]  a, a_delayed;
  logic [1:0]  tap_sel;
  logic        a_delayed_valid;
  logic [2:0]  occupancy;

  logic        b_en, b_flush, b_a_valid, b_delayed_valid;
  logic [31:0] b_a, b_delayed;
  logic [1:0]  b_tap, b_occ;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] sb_q [$];
  logic [5:0]  bq   [$];

  delay_line_param u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .a(a), .a_valid(a_valid),
    .tap_sel(tap_sel), .a_delayed(a_delayed), .a_delayed_valid(a_delayed_valid),
    .occupancy(occupancy)
  );

  delay_line_param #(.WIDTH(32), .DEPTH(3), .NEG_EDGE(1'b0), .RESET_VAL(32'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .en(b_en), .flush(b_flush), .a(b_a), .a_valid(b_a_valid),
    .tap_sel(b_tap), .a_delayed(b_delayed), .a_delayed_valid(b_delayed_valid),
    .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic pstep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          exp_occ [5];
    logic        bv      [7];
    logic [4:0]  bd      [7];
    int          bocc    [7];
    logic [5:0]  e;

    exp_occ = '{1, 2, 3, 4, 4};
    bv      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bd      = '{5'h03, 5'h1E, 5'h06, 5'h00, 5'h00, 5'h00, 5'h00};
    bocc    = '{1, 1, 2, 2, 1, 1, 0};

    reset_n = 1'b1; en = 1'b1; flush = 1'b0; a = 5'h1F; a_valid = 1'b1; tap_sel = 2'd0;
    b_en = 1'b0; b_flush = 1'b0; b_a = 32'h0; b_a_valid = 1'b0; b_tap = 2'd0;
    #1 reset_n = 1'b0;

    // reset held across active edges
    repeat (3) begin
      nstep();
      check("rst_data", 32'(a_delayed), 32'h0);
      check("rst_valid", 32'(a_delayed_valid), 32'h0);
      check("rst_occ", 32'(occupancy), 32'h0);
    end
    check("rst_b_data", b_delayed, 32'h0);
    check("rst_b_occ", 32'(b_occ), 32'h0);

    @(posedge clk); #1 reset_n = 1'b1;
    nstep();
    check("cap_data", 32'(a_delayed), 32'h1F);
    check("cap_valid", 32'(a_delayed_valid), 32'h1);
    check("cap_occ", 32'(occupancy), 32'h1);

    // asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    check("async_data", 32'(a_delayed), 32'h0);
    check("async_valid", 32'(a_delayed_valid), 32'h0);
    check("async_occ", 32'(occupancy), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // latency sweep
    for (int i = 1; i <= 5; i++) begin
      a = 5'(i); a_valid = 1'b1;
      sb_q.push_back(32'(i));
      nstep();
      check("lat_t0_data", 32'(a_delayed), sb_q.pop_front());
      check("lat_t0_valid", 32'(a_delayed_valid), 32'h1);
      check("lat_occ", 32'(occupancy), 32'(exp_occ[i-1]));
      if (i == 4) begin
        tap_sel = 2'd3; #1;
        check("lat_t3_data", 32'(a_delayed), 32'h1);
        tap_sel = 2'd0; #1;
      end
    end
    tap_sel = 2'd2; #1;
    check("tap2_data", 32'(a_delayed), 32'h3);
    tap_sel = 2'd0; #1;
    check("tap0_back", 32'(a_delayed), 32'h5);

    // flush beats enable
    flush = 1'b1; en = 1'b1; a = 5'h0A; a_valid = 1'b1;
    nstep();
    check("flush_occ", 32'(occupancy), 32'h0);
    check("flush_valid", 32'(a_delayed_valid), 32'h0);
    check("flush_data_t0", 32'(a_delayed), 32'h5);
    tap_sel = 2'd3; #1;
    check("flush_valid_t3", 32'(a_delayed_valid), 32'h0);
    check("flush_data_t3", 32'(a_delayed), 32'h2);
    tap_sel = 2'd0;
    flush = 1'b0;

    // stall
    for (int i = 0; i < 3; i++) begin
      a = 5'(7 + i); a_valid = 1'b1;
      nstep();
      check("fill_occ", 32'(occupancy), 32'(i + 1));
    end
    en = 1'b0; a = 5'h15; a_valid = 1'b1;
    repeat (3) begin
      nstep();
      check("stall_occ", 32'(occupancy), 32'h3);
      check("stall_data", 32'(a_delayed), 32'h9);
    end
    tap_sel = 2'd3; #1;
    check("stall_t3_valid", 32'(a_delayed_valid), 32'h0);
    check("stall_t3_data", 32'(a_delayed), 32'h5);
    en = 1'b1; a_valid = 1'b0;
    nstep();
    check("resume_t3_data", 32'(a_delayed), 32'h7);
    check("resume_t3_valid", 32'(a_delayed_valid), 32'h1);
    check("resume_occ", 32'(occupancy), 32'h3);

    // bubble and drain at tap 3
    flush = 1'b1;
    nstep();
    check("bub_flush_occ", 32'(occupancy), 32'h0);
    flush = 1'b0;
    repeat (3) bq.push_back(6'h00);
    for (int i = 0; i < 7; i++) begin
      a = bd[i]; a_valid = bv[i];
      bq.push_back({bv[i], bd[i]});
      nstep();
      e = bq.pop_front();
      check("bub_valid", 32'(a_delayed_valid), 32'(e[5]));
      if (e[5]) check("bub_data", 32'(a_delayed), 32'(e[4:0]));
      check("bub_occ", 32'(occupancy), 32'(bocc[i]));
    end

    // posedge, 32-bit, depth 3 instance
    b_a = 32'hDEADBEEF; b_a_valid = 1'b1; b_en = 1'b1; b_tap = 2'd0;
    pstep();
    check("b_cap_data", b_delayed, 32'hDEADBEEF);
    check("b_cap_valid", 32'(b_delayed_valid), 32'h1);
    check("b_cap_occ", 32'(b_occ), 32'h1);
    @(negedge clk);
    b_a = 32'h12345678;
    #1;
    check("b_negedge_hold", b_delayed, 32'hDEADBEEF);
    check("b_negedge_occ", 32'(b_occ), 32'h1);
    pstep();
    check("b_t0_data", b_delayed, 32'h12345678);
    b_tap = 2'd3; #1;
    check("b_sat_valid_empty", 32'(b_delayed_valid), 32'h0);
    check("b_sat_data_empty", b_delayed, 32'h0);
    b_tap = 2'd1; #1;
    check("b_t1_data", b_delayed, 32'hDEADBEEF);
    b_a = 32'hCAFEF00D; b_tap = 2'd3;
    pstep();
    check("b_sat_data", b_delayed, 32'hDEADBEEF);
    check("b_sat_valid", 32'(b_delayed_valid), 32'h1);
    check("b_full_occ", 32'(b_occ), 32'h3);
    b_tap = 2'd2; #1;
    check("b_t2_data", b_delayed, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
